// File: rtl/ram_single_port_64x8.sv
// ram_single_port_64x8: 2**ADDR_WIDTH x DATA_WIDTH simple-dual-address RAM (one write port, one read port)
// Latency: write visible to a read at the following edge; read data registered, 1 cycle after address
// Backpressure: none -- accepts one write and one read every cycle, no handshake
//
// Ports:
//   clk          clock, all state changes on the rising edge
//   rst          synchronous active-high reset; clears the array and q, drops that cycle's write
//   data         write data
//   write_addr   write address
//   read_addr    read address
//   write_enable active-high write strobe
//   q            registered read data
module ram_single_port_64x8 #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 6
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] data,
   input  logic [ADDR_WIDTH-1:0] write_addr,
   input  logic [ADDR_WIDTH-1:0] read_addr,
   input  logic                  write_enable,
   output logic [DATA_WIDTH-1:0] q
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] rd_q;
   logic [DATA_WIDTH-1:0] rd_d;

   // Read-during-write to the same word returns the pre-write contents:
   // rd_d samples the array before this edge's non-blocking write lands.
   always_comb begin
      rd_d = mem_q[read_addr];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mem_q <= '{default: '0};
         rd_q  <= '0;
      end else begin
         // An unknown strobe takes the else path in simulation, so it never
         // corrupts the array.
         if (write_enable) begin
            mem_q[write_addr] <= data;
         end
         rd_q <= rd_d;
      end
   end

   assign q = rd_q;

endmodule

// File: tb/tb_ram_single_port_64x8.sv
// tb_ram_single_port_64x8: directed vector bench for ram_single_port_64x8
// Latency: each vector is driven at a falling edge and its q checked 1 time unit after the next rising edge
// Backpressure: none -- the DUT has no handshake
module tb_ram_single_port_64x8;

   logic       clk;
   logic       rst;
   logic [7:0] data;
   logic [5:0] write_addr;
   logic [5:0] read_addr;
   logic       write_enable;
   logic [7:0] q;

   int n_vec;
   int n_err;

   typedef struct {
      logic       rst;
      logic       we;
      logic [5:0] wa;
      logic [5:0] ra;
      logic [7:0] d;
      logic [7:0] exp_q;
   } vec_t;

   localparam int NVEC = 25;
   vec_t vecs [NVEC];

   ram_single_port_64x8 #(
      .DATA_WIDTH(8),
      .ADDR_WIDTH(6)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .data        (data),
      .write_addr  (write_addr),
      .read_addr   (read_addr),
      .write_enable(write_enable),
      .q           (q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [7:0] exp_q);
      n_vec++;
      if (q !== exp_q) begin
         n_err++;
         $display("FAIL %s: q=%02h expected %02h", name, q, exp_q);
      end
   endtask

   task automatic drive(input logic r, input logic we, input logic [5:0] wa,
                        input logic [5:0] ra, input logic [7:0] d);
      rst          = r;
      write_enable = we;
      write_addr   = wa;
      read_addr    = ra;
      data         = d;
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      drive(1'b1, 1'b0, 6'd0, 6'd0, 8'h00);

      //             rst   we    wa     ra     d      exp_q
      vecs[0]  = '{1'b1, 1'b0, 6'd0,  6'd0,  8'h00, 8'h00}; // reset edge: q cleared
      vecs[1]  = '{1'b0, 1'b0, 6'd0,  6'd0,  8'h00, 8'h00};
      vecs[2]  = '{1'b0, 1'b0, 6'd0,  6'd1,  8'h00, 8'h00};
      vecs[3]  = '{1'b0, 1'b0, 6'd0,  6'd63, 8'h00, 8'h00};
      vecs[4]  = '{1'b0, 1'b1, 6'd1,  6'd0,  8'h01, 8'h00}; // write 01@1
      vecs[5]  = '{1'b0, 1'b1, 6'd2,  6'd0,  8'h02, 8'h00}; // write 02@2
      vecs[6]  = '{1'b0, 1'b0, 6'd0,  6'd1,  8'h00, 8'h01};
      vecs[7]  = '{1'b0, 1'b0, 6'd0,  6'd2,  8'h00, 8'h02};
      vecs[8]  = '{1'b0, 1'b1, 6'd3,  6'd3,  8'h03, 8'h00}; // RDW: old data
      vecs[9]  = '{1'b0, 1'b0, 6'd0,  6'd3,  8'h00, 8'h03};
      vecs[10] = '{1'b0, 1'b1, 6'd10, 6'd2,  8'hA5, 8'h02}; // independent ports
      vecs[11] = '{1'b0, 1'b0, 6'd0,  6'd10, 8'h00, 8'hA5};
      vecs[12] = '{1'b0, 1'b0, 6'd4,  6'd4,  8'hFF, 8'h00}; // we=0 gating
      vecs[13] = '{1'b0, 1'b0, 6'd0,  6'd4,  8'h00, 8'h00};
      vecs[14] = '{1'b0, 1'b1, 6'd63, 6'd1,  8'h7E, 8'h01}; // boundary 63
      vecs[15] = '{1'b0, 1'b1, 6'd0,  6'd63, 8'h81, 8'h7E}; // boundary 0
      vecs[16] = '{1'b0, 1'b0, 6'd0,  6'd0,  8'h00, 8'h81};
      vecs[17] = '{1'b0, 1'b0, 6'd0,  6'd63, 8'h00, 8'h7E};
      vecs[18] = '{1'b0, 1'b1, 6'd5,  6'd0,  8'h77, 8'h81};
      vecs[19] = '{1'b0, 1'b0, 6'd0,  6'd5,  8'h00, 8'h77};
      vecs[20] = '{1'b1, 1'b1, 6'd5,  6'd5,  8'h5A, 8'h00}; // reset mid-op, write dropped
      vecs[21] = '{1'b0, 1'b0, 6'd0,  6'd5,  8'h00, 8'h00};
      vecs[22] = '{1'b0, 1'b0, 6'd0,  6'd1,  8'h00, 8'h00};
      vecs[23] = '{1'b0, 1'b0, 6'd0,  6'd63, 8'h00, 8'h00};
      vecs[24] = '{1'b0, 1'b0, 6'd0,  6'd10, 8'h00, 8'h00};

      for (int i = 0; i < NVEC; i++) begin
         @(negedge clk);
         drive(vecs[i].rst, vecs[i].we, vecs[i].wa, vecs[i].ra, vecs[i].d);
         @(posedge clk);
         #1;
         check($sformatf("vec%0d", i), vecs[i].exp_q);
      end

      // q holds between edges and has no combinational path from inputs.
      @(negedge clk);
      drive(1'b0, 1'b1, 6'd7, 6'd7, 8'h3C);
      @(posedge clk);
      #1;
      check("hold_rdw_old", 8'h00);
      @(negedge clk);
      drive(1'b0, 1'b0, 6'd0, 6'd7, 8'h00);
      @(posedge clk);
      #1;
      check("hold_read7", 8'h3C);
      @(negedge clk);
      drive(1'b0, 1'b0, 6'd9, 6'd1, 8'hEE);
      #1;
      check("hold_mid_cycle", 8'h3C);
      @(posedge clk);
      #1;
      check("hold_next_edge", 8'h00);

      // Sustained write+read every cycle: pipeline of writes read back one behind.
      @(negedge clk);
      drive(1'b0, 1'b1, 6'd20, 6'd7, 8'hA1);
      @(posedge clk);
      #1;
      check("stream0", 8'h3C);
      @(negedge clk);
      drive(1'b0, 1'b1, 6'd21, 6'd20, 8'hA2);
      @(posedge clk);
      #1;
      check("stream1", 8'hA1);
      @(negedge clk);
      drive(1'b0, 1'b0, 6'd0, 6'd21, 8'h00);
      @(posedge clk);
      #1;
      check("stream2", 8'hA2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
